// File: rtl/cpu_pkg.sv
// Shared processor definitions: opcode constants, opcode class ranges,
// the flag update mask and the flag bundle.
// Used by the flag producer (flag_unit) and by the branch-condition logic.
package cpu_pkg;

  // Arithmetic class: updates sign, carry and zero.
  localparam logic [5:0] OP_ADD = 6'b000000;
  localparam logic [5:0] OP_ADC = 6'b000001;
  localparam logic [5:0] OP_SUB = 6'b000010;
  localparam logic [5:0] OP_SBB = 6'b000011;
  // Logical/shift class: updates sign and zero; carry holds.
  localparam logic [5:0] OP_AND = 6'b000100;
  localparam logic [5:0] OP_OR  = 6'b000101;
  localparam logic [5:0] OP_SHL = 6'b000110;
  // Branch opcodes: consume flags and never produce them.
  localparam logic [5:0] OP_BEQ = 6'b000111;
  localparam logic [5:0] OP_BNE = 6'b001000;
  localparam logic [5:0] OP_BLT = 6'b001001;
  localparam logic [5:0] OP_BGE = 6'b001010;
  localparam logic [5:0] OP_BCS = 6'b001011;
  localparam logic [5:0] OP_BCC = 6'b001100;
  localparam logic [5:0] OP_BMI = 6'b001101;
  localparam logic [5:0] OP_JMP = 6'b001110;

  // Class ranges, inclusive.
  localparam logic [5:0] ARITH_LO  = OP_ADD;
  localparam logic [5:0] ARITH_HI  = OP_SBB;
  localparam logic [5:0] LOGIC_LO  = OP_AND;
  localparam logic [5:0] LOGIC_HI  = OP_SHL;
  localparam logic [5:0] BRANCH_LO = OP_BEQ;
  localparam logic [5:0] BRANCH_HI = OP_JMP;

  // Update mask: bit MASK_SZ covers sign and zero, bit MASK_C covers carry.
  typedef logic [1:0] upd_mask_t;
  localparam int MASK_SZ = 0;
  localparam int MASK_C  = 1;

  typedef struct packed {
    logic sign;
    logic carry;
    logic zero;
  } flag_t;

  typedef enum logic {
    S1_EMPTY = 1'b0,
    S1_FULL  = 1'b1
  } s1_state_t;

  // ARITH_LO is zero, so only the upper bound is compared for that class.
  function automatic upd_mask_t decode_mask(input logic [5:0] op);
    upd_mask_t m;
    m = '0;
    if (op <= ARITH_HI) begin
      m[MASK_SZ] = 1'b1;
      m[MASK_C]  = 1'b1;
    end else if (op >= LOGIC_LO && op <= LOGIC_HI) begin
      m[MASK_SZ] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/flag_eval.sv
// Next sign/zero evaluation from a result word; purely combinational.
// Latency: none. Backpressure: none (no state).
// Ports: result (in, WIDTH) -> sign_next (MSB), zero_next (result == 0).
module flag_eval #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] result,
  output logic             sign_next,
  output logic             zero_next
);

  // The wide zero reduction lives here on its own so it can be timed and
  // floorplanned separately from the flag registers.
  assign sign_next = result[WIDTH-1];
  assign zero_next = ~|result;

endmodule

// File: rtl/flag_unit.sv
// Status-flag producer: captures ALU results and writes sign/carry/zero.
// Latency: accept at edge N, flags written at edge N+1 plus one per stall cycle.
// Backpressure: alu_ready = !stall; stalled input is ignored, S1 and flags hold.
// Ports: clk, rst_n (async, active-low); alu_valid/alu_ready handshake with
//   alu_opcode, alu_result, alu_carry; stall, flush controls; registered
//   sign/carry/zero and flags_pending outputs.
// Optional FLAG_SAVE_EN adds save/restore inputs and a 3-bit flag shadow.
module flag_unit
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alu_valid,
  output logic             alu_ready,
  input  logic [5:0]       alu_opcode,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carry,
  input  logic             stall,
  input  logic             flush,
`ifdef FLAG_SAVE_EN
  input  logic             save,
  input  logic             restore,
`endif
  output logic             sign,
  output logic             carry,
  output logic             zero,
  output logic             flags_pending
);

  s1_state_t        state_q, state_d;
  logic [WIDTH-1:0] res_q;
  logic             carry_q;
  upd_mask_t        mask_q;
  flag_t            flags_q, flags_d;

  logic             wb_en;
  logic             cap_en;
  logic             restore_en;
  logic             sign_next;
  logic             zero_next;
  flag_t            shadow_val;

`ifdef FLAG_SAVE_EN
  flag_t shadow_q, shadow_d;

  assign restore_en = restore;
  assign shadow_val = shadow_q;

  // A save coinciding with a writeback captures the flags as they were
  // before that edge; restore wins over save and leaves the shadow alone.
  always_comb begin
    shadow_d = shadow_q;
    if (save && !restore) shadow_d = flags_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) shadow_q <= '0;
    else        shadow_q <= shadow_d;
  end
`else
  assign restore_en = 1'b0;
  assign shadow_val = '0;
`endif

  flag_eval #(.WIDTH(WIDTH)) u_flag_eval (
    .result    (res_q),
    .sign_next (sign_next),
    .zero_next (zero_next)
  );

  assign alu_ready = !stall;

  // S1 control. Flush (and restore) kills the held entry and any
  // simultaneous accept; stall freezes everything; otherwise the held entry
  // writes back while a new one may be captured on the same edge.
  always_comb begin
    state_d = state_q;
    wb_en   = 1'b0;
    cap_en  = 1'b0;
    if (flush || restore_en) begin
      state_d = S1_EMPTY;
    end else if (!stall) begin
      wb_en   = (state_q == S1_FULL);
      cap_en  = alu_valid;
      state_d = alu_valid ? S1_FULL : S1_EMPTY;
    end
  end

  always_comb begin
    flags_d = flags_q;
    if (restore_en) begin
      flags_d = shadow_val;
    end else if (wb_en) begin
      if (mask_q[MASK_SZ]) begin
        flags_d.sign = sign_next;
        flags_d.zero = zero_next;
      end
      if (mask_q[MASK_C]) flags_d.carry = carry_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S1_EMPTY;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q   <= '0;
      carry_q <= 1'b0;
      mask_q  <= '0;
    end else if (cap_en) begin
      res_q   <= alu_result;
      carry_q <= alu_carry;
      mask_q  <= decode_mask(alu_opcode);
    end
  end

  assign sign          = flags_q.sign;
  assign carry         = flags_q.carry;
  assign zero          = flags_q.zero;
  assign flags_pending = (state_q == S1_FULL) && (mask_q != '0);

endmodule

// File: tb/tb_flag_unit.sv
// Directed bench for flag_unit with a queue of expected flag writebacks.
module tb_flag_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid;
  logic        alu_ready;
  logic [5:0]  alu_opcode;
  logic [31:0] alu_result;
  logic        alu_carry;
  logic        stall;
  logic        flush;
  logic        sign, carry, zero, flags_pending;
`ifdef FLAG_SAVE_EN
  logic        save;
  logic        restore;
`endif

  always #5 clk = ~clk;

  flag_unit #(.WIDTH(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .alu_valid     (alu_valid),
    .alu_ready     (alu_ready),
    .alu_opcode    (alu_opcode),
    .alu_result    (alu_result),
    .alu_carry     (alu_carry),
    .stall         (stall),
    .flush         (flush),
`ifdef FLAG_SAVE_EN
    .save          (save),
    .restore       (restore),
`endif
    .sign          (sign),
    .carry         (carry),
    .zero          (zero),
    .flags_pending (flags_pending)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Expected flags as {sign, carry, zero}.
  logic [2:0] model;
  logic [2:0] sb_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] predict(input logic [5:0] op, input logic [31:0] r,
                                         input logic c, input logic [2:0] cur);
    logic [2:0] f;
    f = cur;
    if (op <= 6'd6) begin
      f[2] = r[31];
      f[0] = (r == 32'd0);
    end
    if (op <= 6'd3) f[1] = c;
    return f;
  endfunction

  // Present a result that will be accepted and later written back.
  task automatic send(input logic [5:0] op, input logic [31:0] r, input logic c);
    alu_valid  = 1'b1;
    alu_opcode = op;
    alu_result = r;
    alu_carry  = c;
    model      = predict(op, r, c, model);
    sb_q.push_back(model);
  endtask

  task automatic idle();
    alu_valid = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare the flag outputs with the oldest outstanding expectation.
  task automatic sb_check(input string tag);
    logic [2:0] exp;
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $error("FAIL %s: observed writeback expected none queued", tag);
    end else begin
      exp = sb_q.pop_front();
      check(tag, {29'd0, sign, carry, zero}, {29'd0, exp});
    end
  endtask

  task automatic flags_hold(input string tag);
    check(tag, {29'd0, sign, carry, zero}, {29'd0, model});
  endtask

  initial begin
    rst_n = 1'b0; alu_valid = 1'b0; alu_opcode = '0; alu_result = '0;
    alu_carry = 1'b0; stall = 1'b0; flush = 1'b0; model = 3'b000;
`ifdef FLAG_SAVE_EN
    save = 1'b0; restore = 1'b0;
`endif
    tick(); tick();
    check("rst_flags", {29'd0, sign, carry, zero}, 32'd0);
    check("rst_pending", {31'd0, flags_pending}, 32'd0);
    check("rst_ready", {31'd0, alu_ready}, 32'd1);
    rst_n = 1'b1;
    tick();

    // Reset while S1 holds an arithmetic entry.
    alu_valid = 1'b1; alu_opcode = 6'd0; alu_result = 32'h8000_0000; alu_carry = 1'b1;
    tick();
    idle();
    check("midrst_pend_before", {31'd0, flags_pending}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_pend", {31'd0, flags_pending}, 32'd0);
    flags_hold("midrst_flags");
    tick();
    rst_n = 1'b1;
    tick();
    flags_hold("midrst_no_write");
    check("midrst_pend_after", {31'd0, flags_pending}, 32'd0);

    // Arithmetic then logical.
    send(6'b000001, 32'd0, 1'b1);
    tick();
    idle();
    check("arith_pend", {31'd0, flags_pending}, 32'd1);
    tick();
    sb_check("arith_flags");
    check("arith_pend_clr", {31'd0, flags_pending}, 32'd0);
    send(6'b000100, 32'h8000_0000, 1'b0);
    tick();
    idle();
    tick();
    sb_check("logic_flags");

    // Branch opcode: accepted but never pending, flags untouched.
    alu_valid = 1'b1; alu_opcode = 6'b001010; alu_result = 32'd0; alu_carry = 1'b0;
    tick();
    idle();
    check("branch_pend", {31'd0, flags_pending}, 32'd0);
    tick();
    check("branch_pend2", {31'd0, flags_pending}, 32'd0);
    flags_hold("branch_flags");

    // Stall for three edges after the accept.
    send(6'b000010, 32'd0, 1'b0);
    tick();
    stall = 1'b1;
    alu_valid = 1'b1; alu_opcode = 6'd0; alu_result = 32'd1; alu_carry = 1'b1;
    #1;
    check("stall_ready", {31'd0, alu_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_pend", {31'd0, flags_pending}, 32'd1);
      check("stall_hold", {29'd0, sign, carry, zero}, 32'b110);
    end
    stall = 1'b0;
    idle();
    #1;
    check("stall_ready_back", {31'd0, alu_ready}, 32'd1);
    tick();
    sb_check("stall_flags");
    check("stall_pend_clr", {31'd0, flags_pending}, 32'd0);

    // Bring zero to 0, then flush an entry that would set it.
    send(6'd0, 32'd3, 1'b0);
    tick();
    idle();
    tick();
    sb_check("preflush_flags");
    alu_valid = 1'b1; alu_opcode = 6'd0; alu_result = 32'd0; alu_carry = 1'b1;
    tick();
    idle();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_pend", {31'd0, flags_pending}, 32'd0);
    flags_hold("flush_flags");
    tick();
    flags_hold("flush_flags_later");
    alu_valid = 1'b1; flush = 1'b1;
    tick();
    idle();
    flush = 1'b0;
    check("flush_acc_pend", {31'd0, flags_pending}, 32'd0);
    tick();
    flags_hold("flush_acc_flags");

    // Back-to-back: zero toggles on consecutive edges.
    send(6'd0, 32'd0, 1'b0);
    tick();
    check("b2b_pend", {31'd0, flags_pending}, 32'd1);
    send(6'd0, 32'd5, 1'b1);
    tick();
    sb_check("b2b_0");
    send(6'd0, 32'd0, 1'b0);
    tick();
    sb_check("b2b_5");
    idle();
    tick();
    sb_check("b2b_0b");
    check("b2b_pend_clr", {31'd0, flags_pending}, 32'd0);

`ifdef FLAG_SAVE_EN
    begin
      logic [2:0] saved;
      saved = model;
      save = 1'b1;
      tick();
      save = 1'b0;
      send(6'd0, 32'h8000_0001, 1'b1);
      tick();
      idle();
      tick();
      sb_check("save_newflags");
      restore = 1'b1;
      tick();
      restore = 1'b0;
      model = saved;
      flags_hold("restore_flags");
      check("restore_pend", {31'd0, flags_pending}, 32'd0);
    end
`endif

    check("sb_drained", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/flag_unit.md
# flag_unit

Producer side of the processor's branch-condition path: registers the sign, carry and zero status flags from ALU results and presents them to the branch-condition logic, which turns a branch opcode plus these flags into a jump decision. Accepts one ALU result per cycle over a valid/ready handshake and computes flags in a two-stage pipeline. Updates only the flags the producing opcode owns. Raises a pending indication so a dependent branch waits for fresh flags.

## Interface
- WIDTH, 32, ALU result width in bits (≥ 2)
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- alu_valid  input  1  ALU result present this cycle
- alu_ready  output  1  unit can accept a result this cycle
- alu_opcode  input  6  opcode that produced the result
- alu_result  input  WIDTH  ALU result
- alu_carry  input  1  carry/borrow out of the ALU
- stall  input  1  hold pipeline contents
- flush  input  1  discard the in-flight result
- sign  output  1  registered sign flag
- carry  output  1  registered carry flag
- zero  output  1  registered zero flag
- flags_pending  output  1  an accepted flag update has not yet reached the flag outputs

## Operation
- Opcode classes:
  - Arithmetic: 6'b000000–6'b000011. Updates sign, carry and zero.
  - Logical/shift: 6'b000100–6'b000110. Updates sign and zero; carry holds.
  - All other opcodes, including branches 6'b000111–6'b001110: no flag update. Such a result is still accepted but never sets flags_pending.
- Stage 1 (S1): on accept (alu_valid && alu_ready), registers alu_result, alu_carry and a 2-bit update mask decoded from alu_opcode. S1 holds one entry with a valid bit.
- Stage 2 (writeback): when S1 is valid and stall is low:
  - sign ← result[WIDTH-1]
  - zero ← (result == 0)
  - carry ← captured alu_carry
  - Each flag is written only if its mask bit is set.
- S1 state machine:
  - EMPTY → FULL on accept.
  - FULL → FULL on accept with no stall; writeback and new capture happen on the same edge.
  - FULL → EMPTY on writeback with no new accept.
- alu_ready = !stall. With stall high, S1 and all flags hold and input is ignored.
- flags_pending = S1 valid && mask != 0.
- flush (synchronous): clears S1 valid. The killed entry never updates any flag; flags keep their prior values. An accept in the same cycle as flush is also discarded.
- Priority: rst_n > flush > stall > normal.
- Reset mid-operation: S1 contents dropped immediately, no partial flag write.

## Timing
- Reset values: sign=0, carry=0, zero=0, flags_pending=0, S1 empty. alu_ready = !stall.
- Latency:
  - Result accepted at edge N → flags_pending high after edge N.
  - Flags updated at edge N+1 (no stall) → flags_pending low after N+1.
  - Each stall cycle adds one cycle of latency.
- Throughput: one result per cycle. Back-to-back updates produce flag changes on consecutive edges.
- Flag outputs come directly from flops; no combinational path from any input to sign/carry/zero.

## Configuration
- FLAG_SAVE_EN defined: adds ports save (in, 1) and restore (in, 1) plus a 3-bit shadow register, reset 0.
  - save copies the current flags to the shadow at the edge. If a writeback happens on the same edge, the shadow gets the pre-writeback value.
  - restore loads the shadow into the flags and clears S1, like flush.
  - restore beats writeback. save and restore together: restore applies, shadow unchanged.
- FLAG_SAVE_EN undefined: no ports, no shadow register, behaviour exactly as above.

## Structure
- Shared package (cpu_pkg): opcode localparams, the class ranges above, the 2-bit update-mask typedef, and the flag-bundle struct {sign, carry, zero}. The branch-condition logic uses the same opcode constants.
- One sub-module, flag_eval. It is combinational and computes the next sign/zero from a result word; it keeps the WIDTH-wide zero reduction isolated for timing.

## Test plan
- Reset: assert rst_n=0 mid-transfer with S1 full → all flags 0, flags_pending 0, no flag write after release.
- Arithmetic, then logical: opcode 6'b000001, result 0, carry 1 accepted at edge N → after N+1: zero=1, carry=1, sign=0. Next, opcode 6'b000100, result 32'h8000_0000 → sign=1, zero=0, carry stays 1.
- Branch opcode 6'b001010 with result 0 → flags unchanged, flags_pending never high.
- Stall: accept at N, stall high N+1..N+3 → flags_pending high through N+3, flags update at N+4, alu_ready low during stall.
- Flush: accept opcode 6'b000000 result 0 at N, flush at N+1 → zero keeps its old value 0, flags_pending low after N+1. A same-cycle flush and accept also yields no update.
- Back-to-back: results 0, 5, 0 with opcode 6'b000000 on consecutive cycles → zero sequence 1, 0, 1 on consecutive edges; with FLAG_SAVE_EN, save then restore returns the saved flags.
